ping_pong_reader: RTL and testbench



---
 rtl/ping_pong_pkg.sv | 22 ++
 rtl/ping_pong_out_fifo.sv | 61 ++++++
 rtl/ping_pong_reader.sv | 133 +++++++++++++
 tb/tb_ping_pong_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// Shared definitions for the ping-pong buffer writer and reader.
package ping_pong_pkg;

  // Reader sequencing: waiting for a full bank, or issuing reads from one.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } pp_state_e;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ping_pong_out_fifo.sv
// Two-entry output FIFO between the bank read port and the streaming output.
// Simultaneous push and pop are both honoured, including when full.
module ping_pong_out_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  // A pop request against an empty FIFO is ignored.
  assign w_pop = i_pop && (r_count != 2'd0);

  // Storage, pointers and occupancy update.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the two entries are reset because the head entry drives the
      // output directly, and that output must read zero out of reset.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

  // The reader's credit rule must never push into a full, unpopped FIFO.
  a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: rtl/ping_pong_reader.sv
// Read side of the ping-pong buffer: drains full banks in strict alternation
// through a 1-cycle-latency read port and streams the words out valid/ready.
module ping_pong_reader
  import ping_pong_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  BANK_DEPTH = 4,
  localparam int ADDR_WIDTH = (clog2(BANK_DEPTH) < 1) ? 1 : clog2(BANK_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            bank_full,
  output logic [1:0]            bank_release,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BANK_DEPTH - 1);

  pp_state_e             r_state;
  pp_state_e             w_state_next;
  logic                  r_bank;        // bank being read, or next bank when idle
  logic                  w_bank_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  r_inflight;    // a read was issued last cycle
  logic [1:0]            r_release;
  logic [1:0]            r_consumed;    // bank already drained since it filled
  logic [1:0]            w_eligible;
  logic                  w_rd_en;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic [1:0]            w_fifo_count;
  logic [2:0]            w_occupancy;
  logic [2:0]            w_credit_limit;

  assign w_eligible = bank_full & ~r_consumed;
  assign w_pop      = data_valid & data_ready;

  // Words held or on their way must stay within the FIFO once this cycle's
  // pop is accounted for, so a read is only issued when a slot is assured.
  assign w_occupancy    = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_credit_limit = 3'd2 + {2'b00, w_pop};
  assign w_credit_ok    = (w_occupancy < w_credit_limit);

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, read strobe and next read address/bank.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next = r_state;
    w_bank_next  = r_bank;
    w_addr_next  = r_addr;
    w_rd_en      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_eligible[r_bank]) begin
          w_state_next = READ;
          w_addr_next  = '0;
        end
      end
      READ: begin
        if (w_credit_ok) begin
          w_rd_en = 1'b1;
          if (r_addr == LAST_ADDR) begin
            // Hand over to the other bank without a bubble if it is ready.
            w_last       = 1'b1;
            w_addr_next  = '0;
            w_bank_next  = ~r_bank;
            w_state_next = w_eligible[~r_bank] ? READ : IDLE;
          end else begin
            w_addr_next = r_addr + ADDR_WIDTH'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read position, in-flight tracking, release pulses and consumed flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bank     <= 1'b0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_release  <= 2'b00;
      r_consumed <= 2'b00;
    end else begin
      r_bank     <= w_bank_next;
      r_addr     <= w_addr_next;
      r_inflight <= w_rd_en;
      r_release  <= w_last ? (r_bank ? 2'b10 : 2'b01) : 2'b00;
      // A released bank stays blocked until the writer drops its full flag.
      r_consumed <= (r_consumed | r_release) & bank_full;
    end
  end

  ping_pong_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_push     (r_inflight),
    .i_push_data(rd_data),
    .i_pop      (w_pop),
    .o_data     (data_output),
    .o_valid    (data_valid),
    .o_count    (w_fifo_count)
  );

  assign rd_en        = w_rd_en;
  assign rd_bank      = r_bank;
  assign rd_addr      = r_addr;
  assign bank_release = r_release;
  assign busy         = (r_state != IDLE) || (w_fifo_count != 2'd0);

endmodule

// File: tb/tb_ping_pong_reader.sv
// Self-checking bench for ping_pong_reader: a transaction-level model of the
// expected read order, streamed words and release pulses, plus literal
// per-cycle expectations for the directed scenarios.
module tb_ping_pong_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LOGN  = 40;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    bank_full;
  logic [1:0]    bank_release;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data_output;
  logic          data_valid;
  logic          data_ready;
  logic          busy;

  ping_pong_reader #(
    .DATA_WIDTH(DW),
    .BANK_DEPTH(DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bank_full   (bank_full),
    .bank_release(bank_release),
    .rd_en       (rd_en),
    .rd_bank     (rd_bank),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .data_output (data_output),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Bank storage with a synchronous, 1-cycle-latency read port.
  logic [DW-1:0] mem [2][DEPTH];
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc - t0);
  endtask

  // Model: expected reads ({bank, addr}) and expected streamed words, in order.
  logic [AW:0]   exp_reads [$];
  logic [DW-1:0] exp_words [$];
  logic [1:0]    exp_release;
  int            outstanding;
  logic          held_valid;
  logic [DW-1:0] held_data;

  // Per-cycle log relative to the start of the current scenario.
  int            t0 = -1000;
  logic          log_rd_en [LOGN];
  logic          log_bank  [LOGN];
  logic [AW-1:0] log_addr  [LOGN];
  logic          log_valid [LOGN];
  logic [DW-1:0] log_data  [LOGN];
  logic [1:0]    log_rel   [LOGN];
  logic          log_busy  [LOGN];

  // Compare process: checks the DUT against the model on every cycle.
  initial begin
    int idx;
    exp_release = 2'b00;
    outstanding = 0;
    held_valid  = 1'b0;
    held_data   = '0;
    forever begin
      @(negedge clock);
      idx = cyc - t0;
      if (idx >= 0 && idx < LOGN) begin
        log_rd_en[idx] = rd_en;
        log_bank[idx]  = rd_bank;
        log_addr[idx]  = rd_addr;
        log_valid[idx] = data_valid;
        log_data[idx]  = data_output;
        log_rel[idx]   = bank_release;
        log_busy[idx]  = busy;
      end
      if (reset) begin
        check("reset_outputs_zero",
              64'({bank_release, rd_en, rd_bank, rd_addr, data_output, data_valid, busy}), 64'd0);
        exp_reads.delete();
        exp_words.delete();
        exp_release = 2'b00;
        outstanding = 0;
        held_valid  = 1'b0;
      end else begin
        check("release_pulse", 64'(bank_release), 64'(exp_release));
        exp_release = 2'b00;
        if (rd_en) begin
          if (exp_reads.size() == 0) begin
            check("unexpected_rd_en", 64'(rd_en), 64'd0);
          end else begin
            check("rd_bank_addr", 64'({rd_bank, rd_addr}), 64'(exp_reads[0]));
            if (exp_reads[0][AW-1:0] == AW'(DEPTH - 1))
              exp_release = exp_reads[0][AW] ? 2'b10 : 2'b01;
            void'(exp_reads.pop_front());
          end
          outstanding++;
        end
        if (held_valid)
          check("hold_stable", 64'({data_valid, data_output}), 64'({1'b1, held_data}));
        if (data_valid && data_ready) begin
          if (exp_words.size() == 0) begin
            check("unexpected_word", 64'(data_valid), 64'd0);
          end else begin
            check("stream_word", 64'(data_output), 64'(exp_words[0]));
            void'(exp_words.pop_front());
          end
          outstanding--;
        end
        check("credit_bound", 64'(outstanding > 2), 64'd0);
        held_valid = data_valid && !data_ready;
        held_data  = data_output;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic begin_test();
    for (int i = 0; i < LOGN; i++) begin
      log_rd_en[i] = 1'b0; log_bank[i] = 1'b0; log_addr[i] = '0;
      log_valid[i] = 1'b0; log_data[i] = '0;   log_rel[i]  = 2'b00; log_busy[i] = 1'b0;
    end
    t0 = cyc;
  endtask

  task automatic expect_bank(input int b);
    for (int i = 0; i < DEPTH; i++) begin
      exp_reads.push_back({b[0], AW'(i)});
      exp_words.push_back(mem[b][i]);
    end
  endtask

  task automatic reset_dut();
    bank_full  = 2'b00;
    data_ready = 1'b1;
    reset      = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic end_test(input string name);
    check({name, "_reads_done"}, 64'(exp_reads.size()), 64'd0);
    check({name, "_words_done"}, 64'(exp_words.size()), 64'd0);
    check({name, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic expect_read_at(input string name, input int k, input logic b, input int a);
    check(name, 64'({log_rd_en[k], log_bank[k], log_addr[k]}), 64'({1'b1, b, AW'(a)}));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[0][i] = 32'hA000_0000 + 32'(i);
      mem[1][i] = 32'hB000_0000 + 32'(i);
    end
    reset      = 1'b1;
    bank_full  = 2'b00;
    data_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single bank, no backpressure.
    begin_test();
    bank_full = 2'b01;
    expect_bank(0);
    tick(12);
    check("t2_no_rd_en_c0", 64'(log_rd_en[0]), 64'd0);
    for (int k = 1; k <= 4; k++) expect_read_at("t2_rd", k, 1'b0, k - 1);
    check("t2_no_rd_en_c5", 64'(log_rd_en[5]), 64'd0);
    check("t2_valid_c2", 64'(log_valid[2]), 64'd0);
    for (int k = 3; k <= 6; k++)
      check("t2_word", 64'({log_valid[k], log_data[k]}), 64'({1'b1, 32'hA000_0000 + 32'(k - 3)}));
    check("t2_valid_c7", 64'(log_valid[7]), 64'd0);
    check("t2_release_c4", 64'(log_rel[4]), 64'd0);
    check("t2_release_c5", 64'(log_rel[5]), 64'h1);
    check("t2_release_c6", 64'(log_rel[6]), 64'd0);
    check("t2_busy_c2", 64'(log_busy[2]), 64'd1);
    end_test("t2");

    // Both banks full: back-to-back with no bubble.
    reset_dut();
    begin_test();
    bank_full = 2'b11;
    expect_bank(0);
    expect_bank(1);
    tick(16);
    for (int k = 1; k <= 8; k++) expect_read_at("t3_rd", k, (k > 4), (k - 1) % 4);
    check("t3_no_rd_en_c9", 64'(log_rd_en[9]), 64'd0);
    for (int k = 3; k <= 10; k++)
      check("t3_word", 64'({log_valid[k], log_data[k]}),
            64'({1'b1, ((k > 6) ? 32'hB000_0000 : 32'hA000_0000) + 32'((k - 3) % 4)}));
    check("t3_release_c5", 64'(log_rel[5]), 64'h1);
    check("t3_release_c9", 64'(log_rel[9]), 64'h2);
    end_test("t3");

    // Reset mid-stream, then restart from bank 0 address 0.
    reset_dut();
    bank_full = 2'b11;
    expect_bank(0);
    expect_bank(1);
    tick(4);
    check("t1_streaming_before_reset", 64'(data_valid), 64'd1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    begin_test();
    expect_bank(0);
    expect_bank(1);
    tick(16);
    check("t1_no_rd_en_c0", 64'(log_rd_en[0]), 64'd0);
    expect_read_at("t1_first_read", 1, 1'b0, 0);
    check("t1_release_c5", 64'(log_rel[5]), 64'h1);
    end_test("t1");

    // Backpressure during bank 0 (data_ready low in cycles 3..6).
    reset_dut();
    begin_test();
    bank_full = 2'b01;
    expect_bank(0);
    for (int k = 0; k < 14; k++) begin
      data_ready = !(k >= 3 && k <= 6);
      tick(1);
    end
    data_ready = 1'b1;
    expect_read_at("t4_rd_c1", 1, 1'b0, 0);
    expect_read_at("t4_rd_c2", 2, 1'b0, 1);
    for (int k = 3; k <= 6; k++) check("t4_stall", 64'(log_rd_en[k]), 64'd0);
    expect_read_at("t4_rd_c7", 7, 1'b0, 2);
    expect_read_at("t4_rd_c8", 8, 1'b0, 3);
    for (int k = 3; k <= 7; k++)
      check("t4_held_a0", 64'({log_valid[k], log_data[k]}), 64'({1'b1, 32'hA000_0000}));
    check("t4_word_c8", 64'(log_data[8]), 64'hA000_0001);
    check("t4_word_c10", 64'(log_data[10]), 64'hA000_0003);
    check("t4_valid_c11", 64'(log_valid[11]), 64'd0);
    check("t4_release_c9", 64'(log_rel[9]), 64'h1);
    end_test("t4");

    // Only bank 1 full: nothing until bank 0 fills, then bank 0 first.
    reset_dut();
    begin_test();
    bank_full = 2'b10;
    tick(6);
    for (int k = 0; k <= 6; k++) check("t5_idle", 64'(log_rd_en[k]), 64'd0);
    bank_full = 2'b11;
    expect_bank(0);
    expect_bank(1);
    tick(18);
    expect_read_at("t5_bank0_first", 7, 1'b0, 0);
    expect_read_at("t5_bank1_next", 11, 1'b1, 0);
    end_test("t5");

    // Held-high full flag is not re-read; a one-cycle drop re-arms it once.
    reset_dut();
    begin_test();
    bank_full = 2'b01;
    expect_bank(0);
    tick(10);
    check("t6_release_c5", 64'(log_rel[5]), 64'h1);
    bank_full = 2'b11;
    expect_bank(1);
    tick(14);
    check("t6_no_reread_reads", 64'(exp_reads.size()), 64'd0);
    begin_test();
    bank_full = 2'b10;
    tick(1);
    bank_full = 2'b11;
    expect_bank(0);
    tick(14);
    check("t6_no_rd_en_c1", 64'(log_rd_en[1]), 64'd0);
    expect_read_at("t6_reread", 2, 1'b0, 0);
    check("t6_release_c6", 64'(log_rel[6]), 64'h1);
    end_test("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
